// File: rtl/test_sequencer.sv
// test_sequencer
//   Runs up to NUM_TESTS self-test channels one at a time in index order and
//   collects per-channel pass/fail, a failure count and the first failing
//   index. Sits between the control/status register file and the BIST
//   engines.
//
// Optional feature macro: TEST_SEQ_TIMEOUT_EN
//   defined   -> a per-test watchdog fails a channel that has not reported
//                done within TIMEOUT_CYCLES cycles of waiting.
//   undefined -> no watchdog; a channel waits for done (or reset) forever.
//
// Ports
//   clock_i, reset_i     clock, asynchronous active-high reset
//   start_i              run request (ignored while busy)
//   stop_on_fail_i       abort after first failure (latched at start)
//   enable_i             per-channel enable mask (latched at start)
//   test_start_o         one-hot, one-cycle launch strobe
//   test_done_i          per-channel done (only the running channel is used)
//   test_pass_i          per-channel result, valid with done
//   busy_o, done_o       run in progress / run finished (held)
//   pass_o               all executed tests passed (valid with done_o)
//   pass_mask_o          per-channel pass bits
//   fail_mask_o          per-channel fail bits (incl. timeouts)
//   fail_count_o         number of failed channels
//   first_fail_o         index of first failure, 0 if none
//   current_o            index being selected or run
module test_sequencer #(
    parameter int NUM_TESTS      = 13,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int IDX_W          = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    parameter int CNT_W          = $clog2(NUM_TESTS + 1)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 stop_on_fail_i,
    input  logic [NUM_TESTS-1:0] enable_i,
    output logic [NUM_TESTS-1:0] test_start_o,
    input  logic [NUM_TESTS-1:0] test_done_i,
    input  logic [NUM_TESTS-1:0] test_pass_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [NUM_TESTS-1:0] pass_mask_o,
    output logic [NUM_TESTS-1:0] fail_mask_o,
    output logic [CNT_W-1:0]     fail_count_o,
    output logic [IDX_W-1:0]     first_fail_o,
    output logic [IDX_W-1:0]     current_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    // The index must be able to reach NUM_TESTS to signal "past the last
    // channel", so it is held at CNT_W bits; the channel-facing view is the
    // low IDX_W bits.
    logic [CNT_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_cur;
    logic [NUM_TESTS-1:0] en_q;
    logic                 sof_q;

    logic accept;    // start accepted in IDLE/FINISH
    logic advance;   // move to the next channel
    logic rec;       // record a result for the current channel
    logic rec_fail;  // ... and that result is a failure

    assign idx_cur = idx[IDX_W-1:0];

`ifdef TEST_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    // Counter is cleared in LAUNCH and counts WAIT cycles; the last allowed
    // WAIT cycle is the one where it holds TIMEOUT_CYCLES-1.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            tmo_cnt <= '0;
        else if (state == S_LAUNCH)
            tmo_cnt <= '0;
        else if (state == S_WAIT && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    // Next state and datapath control.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        rec       = 1'b0;
        rec_fail  = 1'b0;
        case (state)
            S_IDLE, S_FINISH: begin
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (idx >= CNT_W'(NUM_TESTS)) begin
                    state_nxt = S_FINISH;
                end else if (!en_q[idx_cur]) begin
                    advance = 1'b1;
                end else begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                // Done takes priority over a timeout on the same edge.
                if (test_done_i[idx_cur]) begin
                    rec      = 1'b1;
                    rec_fail = !test_pass_i[idx_cur];
                end
`ifdef TEST_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    rec      = 1'b1;
                    rec_fail = 1'b1;
                end
`endif
                if (rec) begin
                    if (rec_fail && sof_q) begin
                        state_nxt = S_FINISH;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = S_SELECT;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            idx          <= '0;
            en_q         <= '0;
            sof_q        <= 1'b0;
            pass_mask_o  <= '0;
            fail_mask_o  <= '0;
            fail_count_o <= '0;
            first_fail_o <= '0;
        end else begin
            if (accept) begin
                idx          <= '0;
                en_q         <= enable_i;
                sof_q        <= stop_on_fail_i;
                pass_mask_o  <= '0;
                fail_mask_o  <= '0;
                fail_count_o <= '0;
                first_fail_o <= '0;
            end
            if (advance)
                idx <= idx + 1'b1;
            if (rec) begin
                if (rec_fail) begin
                    fail_mask_o[idx_cur] <= 1'b1;
                    if (fail_count_o == '0)
                        first_fail_o <= idx_cur;
                    if (fail_count_o != CNT_W'(NUM_TESTS))
                        fail_count_o <= fail_count_o + 1'b1;
                end else begin
                    pass_mask_o[idx_cur] <= 1'b1;
                end
            end
        end
    end

    // Decoded from state so the strobe drops as soon as reset is applied.
    assign test_start_o = (state == S_LAUNCH) ? (NUM_TESTS'(1) << idx_cur) : '0;
    assign busy_o       = (state == S_SELECT) || (state == S_LAUNCH) || (state == S_WAIT);
    assign done_o       = (state == S_FINISH);
    assign pass_o       = done_o && (fail_count_o == '0);
    assign current_o    = idx_cur;

endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;
    localparam int N  = 4;
    localparam int T  = 16;
    localparam int CW = 3;
    localparam int IW = 2;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic          stop_on_fail_i = 1'b0;
    logic [N-1:0]  enable_i = '0;
    logic [N-1:0]  test_start_o;
    logic [N-1:0]  test_done_i;
    logic [N-1:0]  test_pass_i;
    logic          busy_o, done_o, pass_o;
    logic [N-1:0]  pass_mask_o, fail_mask_o;
    logic [CW-1:0] fail_count_o;
    logic [IW-1:0] first_fail_o, current_o;

    test_sequencer #(.NUM_TESTS(N), .TIMEOUT_CYCLES(T)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
        .stop_on_fail_i(stop_on_fail_i), .enable_i(enable_i),
        .test_start_o(test_start_o), .test_done_i(test_done_i),
        .test_pass_i(test_pass_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .pass_mask_o(pass_mask_o), .fail_mask_o(fail_mask_o),
        .fail_count_o(fail_count_o), .first_fail_o(first_fail_o),
        .current_o(current_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Channel responder settings: done arrives dly[i] cycles after the strobe.
    int           dly [N];
    bit           res [N];
    int           cd  [N];
    logic [N-1:0] noise = '0;

    // Expected behaviour of one run, as a timeline relative to the cycle in
    // which the accepted start takes effect (offset 0).
    logic [N-1:0] exp_strobe [0:511];
    int           exp_fin;
    int           run_base = 0;
    bit           chk_en = 0;
    logic [N-1:0] exp_pmask, exp_fmask;
    int           exp_fcnt, exp_ff;
    bit           exp_pass;

    // Each enabled channel: one cycle of selection, a strobe, d cycles of
    // waiting, then selection resumes. A disabled channel costs one cycle.
    // One more selection cycle past the last channel precedes the finish.
    task automatic build_model(input logic [N-1:0] en, input bit sof);
        int  c, l, d;
        bit  f, stopped;
        for (int k = 0; k < 512; k++) exp_strobe[k] = '0;
        exp_pmask = '0; exp_fmask = '0; exp_fcnt = 0; exp_ff = 0;
        c = 0; stopped = 0;
        for (int i = 0; i < N && !stopped; i++) begin
            if (!en[i]) begin
                c = c + 1;
            end else begin
                l = c + 1;
                d = dly[i];
                f = !res[i];
`ifdef TEST_SEQ_TIMEOUT_EN
                if (d > T) begin d = T; f = 1; end
`endif
                exp_strobe[l] = N'(1) << i;
                c = l + d + 1;
                if (f) begin
                    if (exp_fcnt == 0) exp_ff = i;
                    exp_fcnt++;
                    exp_fmask[i] = 1'b1;
                    if (sof) stopped = 1;
                end else begin
                    exp_pmask[i] = 1'b1;
                end
            end
        end
        exp_fin  = stopped ? c : c + 1;
        exp_pass = (exp_fcnt == 0);
    endtask

    // Responder for the self-test channels; disabled channels hold done high
    // with pass low, which the sequencer must ignore.
    initial begin
        logic [N-1:0] d, p;
        test_done_i = '0;
        test_pass_i = '0;
        for (int i = 0; i < N; i++) cd[i] = 0;
        forever begin
            @(negedge clock_i);
            d = noise;
            p = '0;
            if (reset_i) begin
                for (int i = 0; i < N; i++) cd[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (cd[i] > 0) begin
                        cd[i] = cd[i] - 1;
                        if (cd[i] == 0) begin
                            d[i] = 1'b1;
                            p[i] = res[i];
                        end
                    end
                end
                for (int i = 0; i < N; i++)
                    if (test_start_o[i]) cd[i] = dly[i];
            end
            test_done_i = d;
            test_pass_i = p;
        end
    end

    // Compare process: every cycle of a run against the model timeline.
    always @(negedge clock_i) begin
        int           off, ci;
        logic [N-1:0] es;
        if (chk_en && !reset_i) begin
            off = cyc - run_base;
            if (off >= 0) begin
                es = (off < 512) ? exp_strobe[off] : '0;
                chk("strobe", int'(test_start_o), int'(es));
                if (es != '0) begin
                    ci = 0;
                    for (int i = 0; i < N; i++) if (es[i]) ci = i;
                    chk("current", int'(current_o), ci);
                end
                chk("busy", int'(busy_o), int'(off < exp_fin));
                chk("done", int'(done_o), int'(off >= exp_fin));
                chk("pass", int'(pass_o), int'(off >= exp_fin && exp_pass));
                if (off >= exp_fin) begin
                    chk("pass_mask", int'(pass_mask_o), int'(exp_pmask));
                    chk("fail_mask", int'(fail_mask_o), int'(exp_fmask));
                    chk("fail_count", int'(fail_count_o), exp_fcnt);
                    chk("first_fail", int'(first_fail_o), exp_ff);
                end
            end
        end
    end

    task automatic set_resp(input int d, input logic [N-1:0] pass_bits);
        for (int i = 0; i < N; i++) begin
            dly[i] = d;
            res[i] = pass_bits[i];
        end
    endtask

    // Called at a negedge: applies start for the next edge.
    task automatic run_start(input logic [N-1:0] en, input bit sof);
        build_model(en, sof);
        noise          = ~en;
        enable_i       = en;
        stop_on_fail_i = sof;
        start_i        = 1'b1;
        run_base       = cyc + 1;
        chk_en         = 1;
        @(negedge clock_i);
        start_i = 1'b0;
    endtask

    // Bounded wait: lands one cycle past the expected finish.
    task automatic run_wait();
        repeat (exp_fin + 1) @(negedge clock_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobe"}, int'(test_start_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_pass"}, int'(pass_o), 0);
        chk({tag, "_pmask"}, int'(pass_mask_o), 0);
        chk({tag, "_fmask"}, int'(fail_mask_o), 0);
        chk({tag, "_fcnt"}, int'(fail_count_o), 0);
        chk({tag, "_ff"}, int'(first_fail_o), 0);
        chk({tag, "_cur"}, int'(current_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        set_resp(3, 4'b1111);
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        chk_all_zero("idle");

        // All four enabled, all pass, done 3 cycles after each strobe.
        set_resp(3, 4'b1111);
        run_start(4'b1111, 1'b0);
        chk("modelA_fin", exp_fin, 21);
        chk("modelA_strobe3", int'(exp_strobe[16]), 4'b1000);
        run_wait();
        chk("A_pmask", int'(pass_mask_o), 4'b1111);
        chk("A_fmask", int'(fail_mask_o), 0);
        chk("A_pass", int'(pass_o), 1);

        // Channels 0 and 2 only; channel 2 fails.
        set_resp(3, 4'b1011);
        run_start(4'b0101, 1'b0);
        chk("modelB_fin", exp_fin, 13);
        run_wait();
        chk("B_pmask", int'(pass_mask_o), 4'b0001);
        chk("B_fmask", int'(fail_mask_o), 4'b0100);
        chk("B_ff", int'(first_fail_o), 2);
        chk("B_fcnt", int'(fail_count_o), 1);
        chk("B_pass", int'(pass_o), 0);

        // Stop on first failure at channel 1.
        set_resp(3, 4'b1101);
        run_start(4'b1111, 1'b1);
        chk("modelC_fin", exp_fin, 10);
        run_wait();
        chk("C_fmask", int'(fail_mask_o), 4'b0010);
        chk("C_pmask", int'(pass_mask_o), 4'b0001);

`ifdef TEST_SEQ_TIMEOUT_EN
        // Channel 0 never answers: fails after 16 waiting cycles.
        set_resp(3, 4'b1111);
        dly[0] = 100000;
        run_start(4'b1111, 1'b0);
        chk("modelT_strobe1", int'(exp_strobe[19]), 4'b0010);
        run_wait();
        chk("T_fmask", int'(fail_mask_o), 4'b0001);
        // Done on the same edge as the timeout: pass.
        dly[0] = T;
        run_start(4'b1111, 1'b0);
        run_wait();
        chk("T2_pmask", int'(pass_mask_o), 4'b1111);
`endif

        // Reset while waiting on channel 2.
        set_resp(3, 4'b1111);
        run_start(4'b1111, 1'b0);
        repeat (12) @(negedge clock_i);
        chk("R_busy_before", int'(busy_o), 1);
        chk("R_cur_before", int'(current_o), 2);
        chk_en  = 0;
        reset_i = 1'b1;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        chk_all_zero("postreset");
        run_start(4'b1111, 1'b0);
        run_wait();
        chk("R_pmask", int'(pass_mask_o), 4'b1111);

        // Nothing enabled; extra starts while busy are ignored.
        run_start(4'b0000, 1'b0);
        chk("modelE_fin", exp_fin, 5);
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        @(negedge clock_i);
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (3) @(negedge clock_i);
        chk("E_done", int'(done_o), 1);
        chk("E_pass", int'(pass_o), 1);
        chk("E_pmask", int'(pass_mask_o), 0);
        chk("E_fmask", int'(fail_mask_o), 0);
        repeat (2) @(negedge clock_i);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
